// File: rtl/data_hs_pipe.sv
// rtl/data_hs_pipe.sv - parametrised valid/ready register-slice pipeline with flush and occupancy
//
// Purpose:
//   Chain of STAGES register slices between two streaming blocks. REG_READY=0 builds
//   bubble-collapsing slices (one word each, ready combinational from downstream);
//   REG_READY=1 builds two-entry skid slices (main + skid register, ready registered,
//   no combinational path from out_ready_i to in_ready_o). Synchronous flush drops
//   every held word; level_o reports the number of words currently held.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous reset, active-high
//   flush_i      synchronous flush, drops all held words and any word offered that cycle
//   in_data_i    upstream data
//   in_valid_i   upstream valid
//   in_ready_o   upstream accept (transfer when in_valid_i & in_ready_o)
//   out_data_o   downstream data
//   out_valid_o  downstream valid
//   out_ready_i  downstream accept
//   level_o      words held across all slices

module data_hs_pipe #(
    parameter int D_WIDTH   = 32,
    parameter int STAGES    = 1,
    parameter int REG_READY = 1,
    parameter int CNT_W     = $clog2(2 * STAGES + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [D_WIDTH-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [D_WIDTH-1:0] out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [CNT_W-1:0]   level_o
);

    // run_q holds in_ready_o low during reset and for no longer than the
    // first edge after release.
    logic                run_q;

    // Slice k: main register (the slice output) and skid register.
    logic [D_WIDTH-1:0]  m_data_q  [STAGES];
    logic [STAGES-1:0]   m_valid_q;
    logic [D_WIDTH-1:0]  s_data_q  [STAGES];
    logic [STAGES-1:0]   s_valid_q;

    // Per-slice view of the upstream side (what feeds slice k) and of the
    // downstream ready (what slice k sees from slice k+1 or the output port).
    logic [D_WIDTH-1:0]  up_data   [STAGES];
    logic [STAGES-1:0]   up_valid;
    logic [STAGES-1:0]   up_ready;
    logic [STAGES-1:0]   dn_ready;
    logic [STAGES-1:0]   up_acc;
    logic                rdy_chain;

    logic                in_xfer;
    logic                out_xfer;

    always_comb begin
        up_data   = '{default: '0};
        up_valid  = '0;
        up_ready  = '0;
        dn_ready  = '0;
        rdy_chain = out_ready_i;

        up_data[0]  = in_data_i;
        up_valid[0] = in_valid_i & run_q;
        for (int k = 1; k < STAGES; k++) begin
            up_data[k]  = m_data_q[k-1];
            up_valid[k] = m_valid_q[k-1];
        end

        // Walk from the output slice back to the input slice. In skid mode the
        // chain is broken at every slice because ready is just ~skid_valid.
        for (int k = STAGES - 1; k >= 0; k--) begin
            dn_ready[k] = rdy_chain;
            if (REG_READY != 0) begin
                rdy_chain = ~s_valid_q[k];
            end else begin
                rdy_chain = rdy_chain | ~m_valid_q[k];
            end
            up_ready[k] = rdy_chain;
        end

        up_acc = up_valid & up_ready;
    end

    assign in_ready_o  = up_ready[0] & run_q;
    assign out_data_o  = m_data_q[STAGES-1];
    assign out_valid_o = m_valid_q[STAGES-1];

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q     <= 1'b0;
            m_valid_q <= '0;
            s_valid_q <= '0;
            level_o   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                m_data_q[k] <= '0;
                s_data_q[k] <= '0;
            end
        end else begin
            run_q <= 1'b1;

            for (int k = 0; k < STAGES; k++) begin
                if (flush_i) begin
                    m_valid_q[k] <= 1'b0;
                    s_valid_q[k] <= 1'b0;
                end else if (REG_READY == 0) begin
                    if (up_ready[k]) begin
                        m_valid_q[k] <= up_valid[k];
                    end
                    if (up_acc[k]) begin
                        m_data_q[k] <= up_data[k];
                    end
                end else if (!m_valid_q[k] || dn_ready[k]) begin
                    // Main register is free this cycle: the skid word is older
                    // than anything offered upstream, so it goes first.
                    if (s_valid_q[k]) begin
                        m_data_q[k]  <= s_data_q[k];
                        m_valid_q[k] <= 1'b1;
                        s_valid_q[k] <= 1'b0;
                    end else begin
                        m_valid_q[k] <= up_acc[k];
                        if (up_acc[k]) begin
                            m_data_q[k] <= up_data[k];
                        end
                    end
                end else if (up_acc[k]) begin
                    // Main is stalled; a word accepted on the registered ready
                    // lands in the skid register.
                    s_data_q[k]  <= up_data[k];
                    s_valid_q[k] <= 1'b1;
                end
            end

            if (flush_i) begin
                level_o <= '0;
            end else if (in_xfer && !out_xfer) begin
                level_o <= level_o + CNT_W'(1);
            end else if (out_xfer && !in_xfer) begin
                level_o <= level_o - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_data_hs_pipe.sv
// tb/tb_data_hs_pipe.sv - self-checking bench for data_hs_pipe in skid and bubble-collapsing modes

module tb_data_hs_pipe;

    localparam int NDUT = 3;
    localparam int STG [NDUT] = '{3, 2, 2};
    localparam int MODE[NDUT] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic [31:0] od [NDUT];
    logic        ov [NDUT];
    logic        ir [NDUT];
    logic [2:0]  lv [NDUT];

    int          vectors = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    logic [31:0] sb [NDUT][$];
    logic        stall [NDUT];
    logic [31:0] held [NDUT];

    always #5 clk = ~clk;

    data_hs_pipe #(.D_WIDTH(32), .STAGES(3), .REG_READY(1)) u_skid3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(ir[0]),
        .out_data_o(od[0]), .out_valid_o(ov[0]), .out_ready_i(out_ready),
        .level_o(lv[0])
    );

    data_hs_pipe #(.D_WIDTH(32), .STAGES(2), .REG_READY(1)) u_skid2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(ir[1]),
        .out_data_o(od[1]), .out_valid_o(ov[1]), .out_ready_i(out_ready),
        .level_o(lv[1])
    );

    data_hs_pipe #(.D_WIDTH(32), .STAGES(2), .REG_READY(0)) u_bub2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(ir[2]),
        .out_data_o(od[2]), .out_valid_o(ov[2]), .out_ready_i(out_ready),
        .level_o(lv[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one FIFO per DUT holding accepted-but-not-delivered
    // words, updated from the handshakes that the coming edge will complete.
    always @(negedge clk) begin
        if (!mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                sb[d].delete();
                stall[d] <= 1'b0;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("d%0d_level", d), 32'(lv[d]), 32'(sb[d].size()));
                chk($sformatf("d%0d_cap", d), 32'(sb[d].size() <= STG[d] * (MODE[d] + 1)), 32'd1);
                if (stall[d]) begin
                    chk($sformatf("d%0d_hold_valid", d), 32'(ov[d]), 32'd1);
                    chk($sformatf("d%0d_hold_data", d), od[d], held[d]);
                end
                if (MODE[d] == 0) begin
                    chk($sformatf("d%0d_ready", d), 32'(ir[d]),
                        32'(out_ready || (sb[d].size() < STG[d])));
                end else if (sb[d].size() < 2) begin
                    chk($sformatf("d%0d_ready", d), 32'(ir[d]), 32'd1);
                end

                if (flush) begin
                    sb[d].delete();
                end else begin
                    if (ov[d] && out_ready) begin
                        if (sb[d].size() == 0) begin
                            chk($sformatf("d%0d_pop_empty", d), 32'(sb[d].size()), 32'd1);
                        end else begin
                            chk($sformatf("d%0d_order", d), od[d], sb[d].pop_front());
                        end
                    end
                    if (in_valid && ir[d]) begin
                        sb[d].push_back(in_data);
                    end
                end
                stall[d] <= ov[d] && !out_ready && !flush;
                held[d]  <= od[d];
            end
        end
    end

    task automatic flush_pulse();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        int exp_lvl;

        // T1: reset with random inputs
        for (int c = 0; c < 3; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            step();
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("t1_d%0d_valid", d), 32'(ov[d]), 32'd0);
                chk($sformatf("t1_d%0d_ready", d), 32'(ir[d]), 32'd0);
                chk($sformatf("t1_d%0d_level", d), 32'(lv[d]), 32'd0);
                chk($sformatf("t1_d%0d_data", d), od[d], 32'd0);
            end
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) chk($sformatf("t1_d%0d_ready_rel", d), 32'(ir[d]), 32'd0);
        step();
        for (int d = 0; d < NDUT; d++) chk($sformatf("t1_d%0d_ready_up", d), 32'(ir[d]), 32'd1);
        mon_en = 1'b1;

        // T2: latency and throughput, 3 skid slices
        flush_pulse();
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            in_valid = (i < 16);
            in_data  = 32'(i);
            if (i < 16) chk("t2_ready", 32'(ir[0]), 32'd1);
            if (i >= 3) begin
                chk("t2_valid", 32'(ov[0]), 32'd1);
                chk("t2_data", od[0], 32'(i - 3));
            end else begin
                chk("t2_valid_early", 32'(ov[0]), 32'd0);
            end
            exp_lvl = ((i < 16) ? i : 16) - ((i > 3) ? (i - 3) : 0);
            chk("t2_level", 32'(lv[0]), 32'(exp_lvl));
            step();
        end
        in_valid = 1'b0;

        // T3: backpressure on 2 skid slices
        out_ready = 1'b0;
        flush_pulse();
        in_valid = 1'b1;
        acc = 0;
        in_data = 32'h100;
        for (int c = 0; c < 8; c++) begin
            if (ir[1]) acc++;
            step();
            in_data = 32'h100 + 32'(acc);
        end
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_ready", 32'(ir[1]), 32'd0);
        chk("t3_level", 32'(lv[1]), 32'd4);
        chk("t3_valid", 32'(ov[1]), 32'd1);
        chk("t3_head", od[1], 32'h100);
        step();
        chk("t3_head_stable", od[1], 32'h100);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t3_drain_valid", 32'(ov[1]), 32'd1);
            chk("t3_drain_data", od[1], 32'h100 + 32'(j));
            step();
        end
        chk("t3_empty_valid", 32'(ov[1]), 32'd0);
        chk("t3_empty_level", 32'(lv[1]), 32'd0);

        // T4: bubble-collapsing slices under backpressure
        out_ready = 1'b0;
        flush_pulse();
        in_valid = 1'b1;
        acc = 0;
        in_data = 32'h200;
        for (int c = 0; c < 5; c++) begin
            if (ir[2]) acc++;
            step();
            in_data = 32'h200 + 32'(acc);
        end
        chk("t4_accepted", 32'(acc), 32'd2);
        chk("t4_level", 32'(lv[2]), 32'd2);
        chk("t4_ready_full", 32'(ir[2]), 32'd0);
        chk("t4_head", od[2], 32'h200);
        out_ready = 1'b1;
        #1;
        chk("t4_ready_follow_hi", 32'(ir[2]), 32'd1);
        out_ready = 1'b0;
        #1;
        chk("t4_ready_follow_lo", 32'(ir[2]), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            chk("t4_drain_data", od[2], 32'h200 + 32'(j));
            step();
        end
        chk("t4_empty_level", 32'(lv[2]), 32'd0);

        // T5: flush with a live input and output handshake in the same cycle
        out_ready = 1'b0;
        flush_pulse();
        in_valid = 1'b1;
        n = 0;
        while (lv[0] != 3'd3 && n < 10) begin
            in_data = 32'hA00 + 32'(n);
            step();
            n++;
        end
        chk("t5_fill_level", 32'(lv[0]), 32'd3);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hBAD;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_valid", 32'(ov[0]), 32'd0);
        chk("t5_level", 32'(lv[0]), 32'd0);
        chk("t5_ready", 32'(ir[0]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_no_ghost", 32'(ov[0]), 32'd0);
        end

        // T6: random traffic, all three configurations against the model
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 299) == 0);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        for (int d = 0; d < NDUT; d++) chk($sformatf("t6_d%0d_drained", d), 32'(lv[d]), 32'd0);

        // Reset in the middle of a stream
        in_valid = 1'b1;
        in_data = 32'hC0DE;
        out_ready = 1'b0;
        repeat (3) step();
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_d%0d_valid", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_d%0d_data", d), od[d], 32'd0);
            chk($sformatf("rst_d%0d_level", d), 32'(lv[d]), 32'd0);
            chk($sformatf("rst_d%0d_ready", d), 32'(ir[d]), 32'd0);
        end
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rel_d%0d_valid", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rel_d%0d_ready", d), 32'(ir[d]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
